signed_addsub_acc: RTL and testbench

- Parametrised successor to the team's fixed-width signed ripple adder.
- Performs signed add, signed subtract, accumulate and accumulator-clear on WIDTH-bit two's-complement operands.
- Result is registered and sign-extended, with a valid/ready handshake on both sides.
- Sits between operand sources (switch/counter logic) and display or downstream arithmetic.

---
 rtl/signed_addsub_acc_pkg.sv | 18 +
 rtl/signed_addsub_acc_if.sv | 25 ++
 rtl/signed_addsub_acc_core.sv | 42 ++++
 rtl/signed_addsub_acc.sv | 95 +++++++++
 tb/tb_signed_addsub_acc.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/signed_addsub_acc_pkg.sv
// Shared op encodings and signed-limit helpers
// for the add/sub/accumulate datapath.
package addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    function automatic int smax(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int smin(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/signed_addsub_acc_if.sv
// Operand/result handshake bundle for
// the signed add/sub accumulator.
interface signed_addsub_acc_if #(
    parameter int WIDTH = 5
);
    logic             InValid;
    logic             InReady;
    logic [1:0]       Op;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH:0]   Sum;
    logic             Ovf;

    modport master (
        output InValid, Op, Ain, Bin, OutReady,
        input  InReady, OutValid, Sum, Ovf
    );

    modport slave (
        input  InValid, Op, Ain, Bin, OutReady,
        output InReady, OutValid, Sum, Ovf
    );
endinterface

// File: rtl/signed_addsub_acc_core.sv
// Ripple-carry signed add/sub built from
// FullAdder cells over sign-extended operands.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module addsub_core #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W:0]   s
);
    logic [W:0] ax;
    logic [W:0] bx;
    logic [W:0] c;

    assign ax   = {a[W-1], a};
    assign bx   = {b[W-1], b} ^ {(W + 1){sub}};
    assign c[0] = sub;

    for (genvar i = 0; i < W; i++) begin : g_fa
        FullAdder u_fa (
            .a  (ax[i]),
            .b  (bx[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // Carry out of the extended sign bit is meaningless.
    assign s[W] = ax[W] ^ bx[W] ^ c[W];
endmodule

// File: rtl/signed_addsub_acc.sv
// Registered signed add/sub/accumulate with
// valid/ready on both sides and wrap or saturate.
module signed_addsub_acc
    import addsub_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int SAT   = 0
) (
    input logic             Clk,
    input logic             Rst,
    signed_addsub_acc_if.slave io
);
    localparam int AW = WIDTH + 1;
    localparam logic [AW-1:0] ACC_MAX = AW'(smax(AW));
    localparam logic [AW-1:0] ACC_MIN = AW'(smin(AW));

    logic          out_valid;
    logic          ovf_q;
    logic [AW-1:0] sum_q;
    logic [AW-1:0] acc_q;
    logic          accept;
    logic          is_sub;
    logic [AW-1:0] as_s;
    logic [AW:0]   raw;
    logic          acc_ovf;
    logic [AW-1:0] acc_lim;
    logic [AW-1:0] nxt_sum;
    logic [AW-1:0] nxt_acc;
    logic          nxt_ovf;

    assign io.InReady  = ~out_valid | io.OutReady;
    assign io.OutValid = out_valid;
    assign io.Sum      = sum_q;
    assign io.Ovf      = ovf_q;
    assign accept      = io.InValid & io.InReady;
    assign is_sub      = (io.Op == OP_SUB);

    addsub_core #(.W(WIDTH)) u_addsub (
        .a   (io.Ain),
        .b   (io.Bin),
        .sub (is_sub),
        .s   (as_s)
    );

    addsub_core #(.W(AW)) u_accum (
        .a   (acc_q),
        .b   ({io.Ain[WIDTH-1], io.Ain}),
        .sub (1'b0),
        .s   (raw)
    );

    // Raw fits in AW signed bits iff its top two bits agree.
    assign acc_ovf = raw[AW] ^ raw[AW-1];

    always_comb begin
        acc_lim = raw[AW-1:0];
        if (SAT != 0 && acc_ovf) begin
            acc_lim = raw[AW] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        nxt_sum = as_s;
        nxt_acc = acc_q;
        nxt_ovf = 1'b0;
        case (io.Op)
            OP_ACC: begin
                nxt_acc = acc_lim;
                nxt_sum = acc_lim;
                nxt_ovf = acc_ovf;
            end
            OP_CLR: begin
                nxt_acc = '0;
                nxt_sum = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            out_valid <= 1'b0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
            acc_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            sum_q     <= nxt_sum;
            ovf_q     <= nxt_ovf;
            acc_q     <= nxt_acc;
        end else if (io.OutReady) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_signed_addsub_acc.sv
// Directed vector bench: wrap and saturate
// instances share one stimulus stream.
module tb_signed_addsub_acc;
    import addsub_pkg::*;

    typedef struct {
        logic [1:0] op;
        int a;
        int b;
        int s0;
        int o0;
        int s1;
        int o1;
    } vec_t;

    logic Clk;
    logic Rst;
    int   total;
    int   bad;
    vec_t tv [16];

    signed_addsub_acc_if #(.WIDTH(5)) p0 ();
    signed_addsub_acc_if #(.WIDTH(5)) p1 ();

    assign p1.InValid  = p0.InValid;
    assign p1.Op       = p0.Op;
    assign p1.Ain      = p0.Ain;
    assign p1.Bin      = p0.Bin;
    assign p1.OutReady = p0.OutReady;

    signed_addsub_acc #(.WIDTH(5), .SAT(0)) dut_wrap (
        .Clk (Clk),
        .Rst (Rst),
        .io  (p0.slave)
    );

    signed_addsub_acc #(.WIDTH(5), .SAT(1)) dut_sat (
        .Clk (Clk),
        .Rst (Rst),
        .io  (p1.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input int a, input int b);
        p0.InValid = 1'b1;
        p0.Op      = op;
        p0.Ain     = 5'(a);
        p0.Bin     = 5'(b);
    endtask

    task automatic edge1();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_out(input string name, input int s0, input int s1);
        chk({name, " valid0"}, int'(p0.OutValid), 1);
        chk({name, " sum0"}, int'($signed(p0.Sum)), s0);
        chk({name, " valid1"}, int'(p1.OutValid), 1);
        chk({name, " sum1"}, int'($signed(p1.Sum)), s1);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        tv[0]  = '{OP_CLR, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{OP_ADD, 15, 15, 30, 0, 30, 0};
        tv[2]  = '{OP_ADD, -16, -16, -32, 0, -32, 0};
        tv[3]  = '{OP_SUB, -16, 15, -31, 0, -31, 0};
        tv[4]  = '{OP_SUB, 15, -16, 31, 0, 31, 0};
        tv[5]  = '{OP_ADD, 0, -1, -1, 0, -1, 0};
        tv[6]  = '{OP_ACC, 15, -16, 15, 0, 15, 0};
        tv[7]  = '{OP_ACC, 15, 7, 30, 0, 30, 0};
        tv[8]  = '{OP_ACC, 15, -1, -19, 1, 31, 1};
        tv[9]  = '{OP_ACC, -1, 3, -20, 0, 30, 0};
        tv[10] = '{OP_ADD, 1, 2, 3, 0, 3, 0};
        tv[11] = '{OP_ACC, -16, 9, 28, 1, 14, 0};
        tv[12] = '{OP_CLR, 5, -5, 0, 0, 0, 0};
        tv[13] = '{OP_ACC, -16, 0, -16, 0, -16, 0};
        tv[14] = '{OP_ACC, -16, 0, -32, 0, -32, 0};
        tv[15] = '{OP_ACC, -1, 15, 31, 1, -32, 1};

        Rst         = 1'b1;
        p0.InValid  = 1'b0;
        p0.Op       = OP_ADD;
        p0.Ain      = '0;
        p0.Bin      = '0;
        p0.OutReady = 1'b1;

        #12;
        chk("rst valid", int'(p0.OutValid), 0);
        chk("rst sum", int'(p0.Sum), 0);
        chk("rst ovf", int'(p0.Ovf), 0);
        chk("rst inready", int'(p0.InReady), 1);
        @(negedge Clk);
        Rst = 1'b0;
        edge1();

        for (int i = 0; i < 16; i++) begin
            drive(tv[i].op, tv[i].a, tv[i].b);
            edge1();
            chk_out($sformatf("vec%0d", i), tv[i].s0, tv[i].s1);
            chk($sformatf("vec%0d ovf0", i), int'(p0.Ovf), tv[i].o0);
            chk($sformatf("vec%0d ovf1", i), int'(p1.Ovf), tv[i].o1);
        end

        // Backpressure: first result must hold and acc stay at 10.
        drive(OP_CLR, 0, 0);
        edge1();
        drive(OP_ACC, 10, 0);
        edge1();
        chk_out("bp first", 10, 10);
        p0.OutReady = 1'b0;
        drive(OP_ACC, 5, 0);
        #1;
        chk("bp inready low", int'(p0.InReady), 0);
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk_out($sformatf("bp hold%0d", i), 10, 10);
            chk($sformatf("bp inready%0d", i), int'(p0.InReady), 0);
        end
        p0.OutReady = 1'b1;
        #1;
        chk("bp inready high", int'(p0.InReady), 1);
        edge1();
        chk_out("bp release", 15, 15);
        edge1();
        chk_out("bp stream", 20, 20);
        p0.InValid = 1'b0;
        edge1();
        chk("drop valid", int'(p0.OutValid), 0);
        chk("drop inready", int'(p0.InReady), 1);

        // Reset while a result is held and acc=30.
        drive(OP_CLR, 0, 0);
        edge1();
        drive(OP_ACC, 15, 0);
        edge1();
        edge1();
        chk_out("pre rst", 30, 30);
        p0.InValid  = 1'b0;
        p0.OutReady = 1'b0;
        #2;
        Rst = 1'b1;
        #1;
        chk("mid rst valid", int'(p0.OutValid), 0);
        chk("mid rst sum", int'(p0.Sum), 0);
        chk("mid rst ovf", int'(p0.Ovf), 0);
        chk("mid rst inready", int'(p0.InReady), 1);
        chk("mid rst valid1", int'(p1.OutValid), 0);
        edge1();
        Rst         = 1'b0;
        p0.OutReady = 1'b1;
        drive(OP_ACC, 1, -7);
        edge1();
        chk_out("post rst acc", 1, 1);
        chk("post rst ovf", int'(p0.Ovf), 0);
        p0.InValid = 1'b0;
        edge1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
